// File: rtl/fmdll_pkg.sv
// fmdll_pkg: definitions shared by the FMDLL blocks.
//   state_t     - lock detector FSM states (UNLOCK / ACQ / LOCK)
//   SYNC_STAGES - depth of the clock-domain-crossing synchroniser
package fmdll_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCK   = 2'd2
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/fd_lock_det_sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser for an asynchronous input, followed
// by a delay flop and a rising-edge detector.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active high
//   din  - asynchronous input
//   rise - high for one clk cycle per synchronised rising edge of din
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            d      <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            d      <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~d;

endmodule

// File: rtl/fd_lock_det.sv
// fd_lock_det: lock detector for the divided feedback clock. Measures the
// div_in period in clk cycles and asserts lock after LOCK_CNT consecutive
// in-tolerance periods; drops it after UNLOCK_CNT consecutive misses.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous reset, active high
//   en         - detector enable
//   div_in     - divided feedback clock (asynchronous)
//   period     - last measured period (all-ones = saturated / timeout)
//   period_vld - one-cycle pulse when period updates
//   lock       - lock indication
//   lock_lost  - one-cycle pulse on LOCK -> UNLOCK
// Build option: define FD_LOCK_DET_TIMEOUT_EN to emit a synthetic all-ones
// measurement whenever the period counter saturates without a rise.
module fd_lock_det
    import fmdll_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 2,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             lock,
    output logic             lock_lost
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam logic [GW-1:0]  LOCK_TGT   = GW'(LOCK_CNT);
    localparam logic [BW-1:0]  UNLOCK_TGT = BW'(UNLOCK_CNT);
    localparam logic [CNT_W:0] EXP_W      = (CNT_W + 1)'(EXP_PERIOD);
    localparam logic [CNT_W:0] TOL_W      = (CNT_W + 1)'(TOL);

    logic             rise;
    logic             timeout;
    logic [CNT_W-1:0] per_cnt;
    logic             first_seen;
    logic [GW-1:0]    good_cnt;
    logic [BW-1:0]    bad_cnt;
    state_t           state;

    logic signed [CNT_W:0] diff;
    logic        [CNT_W:0] mag;
    logic                  match;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (div_in),
        .rise (rise)
    );

    // A rise in the same cycle as saturation takes priority over timeout.
`ifdef FD_LOCK_DET_TIMEOUT_EN
    assign timeout = (per_cnt == '1) && !rise;
`else
    assign timeout = 1'b0;
`endif

    // Saturated count is never a match, whatever the tolerance.
    always_comb begin
        diff  = $signed({1'b0, period}) - $signed(EXP_W);
        mag   = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
        match = (mag <= TOL_W) && (period != '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt    <= '0;
            first_seen <= 1'b0;
            period     <= '0;
            period_vld <= 1'b0;
            lock       <= 1'b0;
            lock_lost  <= 1'b0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            state      <= ST_UNLOCK;
        end else if (!en) begin
            per_cnt    <= '0;
            first_seen <= 1'b0;
            period_vld <= 1'b0;
            lock       <= 1'b0;
            lock_lost  <= (state == ST_LOCK);
            good_cnt   <= '0;
            bad_cnt    <= '0;
            state      <= ST_UNLOCK;
        end else begin
            period_vld <= 1'b0;
            lock_lost  <= 1'b0;

            // Period measurement; the first rise after reset/enable only arms.
            if (rise) begin
                per_cnt    <= CNT_W'(1);
                first_seen <= 1'b1;
                if (first_seen) begin
                    period     <= per_cnt;
                    period_vld <= 1'b1;
                end
            end else if (timeout) begin
                per_cnt    <= CNT_W'(1);
                period     <= '1;
                period_vld <= 1'b1;
            end else if (per_cnt != '1) begin
                per_cnt <= per_cnt + 1'b1;
            end

            // FSM steps on the registered measurement, so lock lags period_vld by one cycle.
            if (period_vld) begin
                case (state)
                    ST_UNLOCK: begin
                        if (match) begin
                            if (LOCK_TGT == GW'(1)) begin
                                state    <= ST_LOCK;
                                lock     <= 1'b1;
                                good_cnt <= '0;
                                bad_cnt  <= '0;
                            end else begin
                                state    <= ST_ACQ;
                                good_cnt <= GW'(1);
                            end
                        end
                    end
                    ST_ACQ: begin
                        if (match) begin
                            if (good_cnt + 1'b1 == LOCK_TGT) begin
                                state    <= ST_LOCK;
                                lock     <= 1'b1;
                                good_cnt <= '0;
                                bad_cnt  <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            state    <= ST_UNLOCK;
                            good_cnt <= '0;
                        end
                    end
                    ST_LOCK: begin
                        if (match) begin
                            bad_cnt <= '0;
                        end else if (bad_cnt + 1'b1 == UNLOCK_TGT) begin
                            state     <= ST_UNLOCK;
                            lock      <= 1'b0;
                            lock_lost <= 1'b1;
                            bad_cnt   <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_UNLOCK;
                        lock     <= 1'b0;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
